// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_pkg
// Brief    : DSP command encodings and command legality helper.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  typedef logic [3:0] dsp_cmd_t;

  localparam dsp_cmd_t CMD_M24    = 4'd0;
  localparam dsp_cmd_t CMD_U16X2  = 4'd2;
  localparam dsp_cmd_t CMD_S16X2  = 4'd3;
  localparam dsp_cmd_t CMD_SU16X2 = 4'd4;
  localparam dsp_cmd_t CMD_U16    = 4'd6;
  localparam dsp_cmd_t CMD_S16    = 4'd7;
  localparam dsp_cmd_t CMD_U32    = 4'd8;
  localparam dsp_cmd_t CMD_S32    = 4'd9;

  // Only the encoded modes are defined for the multiplier.
  function automatic logic cmd_legal(input dsp_cmd_t cmd);
    case (cmd)
      CMD_M24, CMD_U16X2, CMD_S16X2, CMD_SU16X2,
      CMD_U16, CMD_S16, CMD_U32, CMD_S32: cmd_legal = 1'b1;
      default:                            cmd_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp.sv
`default_nettype none
// ============================================================================
// Module   : dsp
// Brief    : Combinational multiplier with mode-selected lane/sign handling.
// Revision : 1.0 - initial release
// ============================================================================
module dsp
  import dsp_pkg::*;
(
  input  logic [31:0] command,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  output logic [63:0] result
);

  logic        [47:0] w_m24;
  logic        [31:0] w_uh, w_ul;
  logic signed [31:0] w_sh, w_sl, w_suh, w_sul;
  logic        [63:0] w_u32;
  logic signed [63:0] w_s32;

  // Operands are widened before multiplying so no product bits are lost.
  assign w_m24 = 48'(in_1[23:0]) * 48'(in_2[23:0]);
  assign w_uh  = 32'(in_1[31:16]) * 32'(in_2[31:16]);
  assign w_ul  = 32'(in_1[15:0]) * 32'(in_2[15:0]);
  assign w_sh  = 32'(signed'(in_1[31:16])) * 32'(signed'(in_2[31:16]));
  assign w_sl  = 32'(signed'(in_1[15:0])) * 32'(signed'(in_2[15:0]));
  assign w_suh = 32'(signed'(in_1[31:16])) * signed'(32'(in_2[31:16]));
  assign w_sul = 32'(signed'(in_1[15:0])) * signed'(32'(in_2[15:0]));
  assign w_u32 = 64'(in_1) * 64'(in_2);
  assign w_s32 = 64'(signed'(in_1)) * 64'(signed'(in_2));

  // Select the product layout for the requested mode; undefined modes give 0.
  always_comb begin
    result = '0;
    case (command)
      32'(CMD_M24):    result = {16'd0, w_m24};
      32'(CMD_U16X2):  result = {w_uh, w_ul};
      32'(CMD_S16X2):  result = {w_sh, w_sl};
      32'(CMD_SU16X2): result = {w_suh, w_sul};
      32'(CMD_U16):    result = {32'd0, w_ul};
      32'(CMD_S16):    result = 64'(w_sl);
      32'(CMD_U32):    result = w_u32;
      32'(CMD_S32):    result = w_s32;
      default:         result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter, one-hot grant, pointer advances on accept.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_win;
  logic           w_found;

  // Scan from the pointer, wrapping, and grant the first active request.
  always_comb begin
    grant   = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (enable && !w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (w_found) grant[w_win] = 1'b1;
  end

  // A grant is always a handshake, so the pointer moves past the winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_ptr <= '0;
    else if (w_found) r_ptr <= IDW'((int'(w_win) + 1) % NREQ);
  end

endmodule
`default_nettype wire

// File: rtl/dsp_sched.sv
`default_nettype none
// ============================================================================
// Module   : dsp_sched
// Brief    : Shares one dsp multiplier among NREQ requesters through a
//            two-stage registered pipeline with a tagged response channel.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_sched
  import dsp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_command,
  input  logic [NREQ*32-1:0] req_in_1,
  input  logic [NREQ*32-1:0] req_in_2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [63:0]       resp_result,
  output logic              resp_err,
  output logic              busy
);

  logic           r_s1_v, r_s1_err;
  dsp_cmd_t       r_s1_cmd;
  logic [31:0]    r_s1_a, r_s1_b;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_v, r_s2_err;
  logic [63:0]    r_s2_res;
  logic [IDW-1:0] r_s2_id;

  logic           w_s2_free, w_s1_adv, w_s1_free, w_arb_en, w_hs;
  logic [NREQ-1:0] w_grant;
  dsp_cmd_t       w_cmd;
  logic [31:0]    w_a, w_b;
  logic [IDW-1:0] w_id;
  logic [31:0]    w_dsp_cmd;
  logic [63:0]    w_dsp_res;

  assign w_s2_free = !r_s2_v | resp_ready;
  assign w_s1_adv  = r_s1_v & w_s2_free;
  assign w_s1_free = !r_s1_v | w_s1_adv;
  // While reset is asserted no grant may be visible.
  assign w_arb_en  = w_s1_free & reset;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (w_arb_en),
    .grant  (w_grant)
  );

  assign req_ready = w_grant;
  assign w_hs      = |w_grant;

  // Route the granted requester's command and operands towards S1.
  always_comb begin
    w_cmd = '0;
    w_a   = '0;
    w_b   = '0;
    w_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_cmd = req_command[4*i +: 4];
        w_a   = req_in_1[32*i +: 32];
        w_b   = req_in_2[32*i +: 32];
        w_id  = IDW'(i);
      end
    end
  end

  // S1: capture the winning operation, or empty when it moves on to S2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v   <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_cmd <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_id  <= '0;
    end else if (w_hs) begin
      r_s1_v   <= 1'b1;
      r_s1_err <= !cmd_legal(w_cmd);
      r_s1_cmd <= w_cmd;
      r_s1_a   <= w_a;
      r_s1_b   <= w_b;
      r_s1_id  <= w_id;
    end else if (w_s1_adv) begin
      r_s1_v   <= 1'b0;
    end
  end

  // The dsp only ever sees a defined mode: idle and illegal ops drive 0.
  assign w_dsp_cmd = (r_s1_v && !r_s1_err) ? 32'(r_s1_cmd) : 32'd0;

  dsp u_dsp (
    .command (w_dsp_cmd),
    .in_1    (r_s1_a),
    .in_2    (r_s1_b),
    .result  (w_dsp_res)
  );

  // S2: register the product, holding it until the consumer accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_v   <= 1'b0;
      r_s2_err <= 1'b0;
      r_s2_res <= '0;
      r_s2_id  <= '0;
    end else if (w_s1_adv) begin
      r_s2_v   <= 1'b1;
      r_s2_err <= r_s1_err;
      r_s2_res <= r_s1_err ? 64'd0 : w_dsp_res;
      r_s2_id  <= r_s1_id;
    end else if (resp_ready) begin
      r_s2_v   <= 1'b0;
    end
  end

  assign resp_valid  = r_s2_v;
  assign resp_id     = r_s2_id;
  assign resp_result = r_s2_res;
  assign resp_err    = r_s2_err;
  assign busy        = r_s1_v | r_s2_v;

endmodule
`default_nettype wire

// File: tb/tb_dsp_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_sched
// Brief    : Self-checking bench for dsp_sched against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*4-1:0] req_command;
  logic [NREQ*32-1:0] req_in_1, req_in_2;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [63:0]       resp_result;
  logic              resp_err, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [63:0] res;
    bit          err;
    int          stamp;
  } op_t;

  op_t q[$];
  int  m_ptr = 0;
  int  cyc   = 0;

  dsp_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_command (req_command),
    .req_in_1    (req_in_1),
    .req_in_2    (req_in_2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_cmd(input int c);
    return c inside {0, 2, 3, 4, 6, 7, 8, 9};
  endfunction

  // Arithmetic meaning of each mode, computed with 64-bit integers.
  function automatic logic [63:0] golden(input int c, input logic [31:0] a, input logic [31:0] b);
    longint p, hi, lo;
    p = 0; hi = 0; lo = 0;
    case (c)
      0: p = longint'(a[23:0]) * longint'(b[23:0]);
      2: begin
        hi = longint'(a[31:16]) * longint'(b[31:16]);
        lo = longint'(a[15:0]) * longint'(b[15:0]);
        p  = {32'(hi), 32'(lo)};
      end
      3: begin
        hi = longint'(signed'(a[31:16])) * longint'(signed'(b[31:16]));
        lo = longint'(signed'(a[15:0])) * longint'(signed'(b[15:0]));
        p  = {32'(hi), 32'(lo)};
      end
      4: begin
        hi = longint'(signed'(a[31:16])) * longint'(b[31:16]);
        lo = longint'(signed'(a[15:0])) * longint'(b[15:0]);
        p  = {32'(hi), 32'(lo)};
      end
      6: p = longint'(a[15:0]) * longint'(b[15:0]);
      7: p = longint'(signed'(a[15:0])) * longint'(signed'(b[15:0]));
      8: p = longint'(a) * longint'(b);
      9: p = longint'(signed'(a)) * longint'(signed'(b));
      default: p = 0;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_8000;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive inputs, compare outputs with the model, then advance it.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*4-1:0] c,
                       input logic [NREQ*32-1:0] a, input logic [NREQ*32-1:0] b,
                       input logic rr, output logic [NREQ-1:0] got);
    int win, cmd;
    bit free, exp_rv;
    logic [NREQ-1:0] exp_ready;
    op_t op;
    @(negedge clk);
    req_valid = v; req_command = c; req_in_1 = a; req_in_2 = b; resp_ready = rr;
    #1;
    exp_rv = (q.size() > 0) && (q[0].stamp < cyc);
    free   = (q.size() - ((exp_rv && rr) ? 1 : 0)) < 2;
    win    = -1;
    if (free)
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    got = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    check("busy", 64'(busy), 64'(q.size() > 0));
    if (exp_rv) begin
      check("resp_id", 64'(resp_id), 64'(q[0].id));
      check("resp_result", resp_result, q[0].res);
      check("resp_err", 64'(resp_err), 64'(q[0].err));
    end
    @(posedge clk);
    cyc++;
    if (exp_rv && rr) void'(q.pop_front());
    if (win >= 0) begin
      cmd      = int'(c[4*win +: 4]);
      op.id    = win;
      op.err   = !legal_cmd(cmd);
      op.res   = op.err ? 64'd0 : golden(cmd, a[32*win +: 32], b[32*win +: 32]);
      op.stamp = cyc;
      q.push_back(op);
      m_ptr = (win + 1) % NREQ;
    end
  endtask

  logic [NREQ-1:0]    g;
  logic [NREQ*4-1:0]  cv;
  logic [NREQ*32-1:0] av, bv;

  initial begin
    reset = 1'b0; req_valid = '1; req_command = '0;
    req_in_1 = '0; req_in_2 = '0; resp_ready = 1'b0;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", resp_result, 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Single unsigned 32x32 op from req0.
    av = '0; bv = '0; cv = '0;
    av[31:0] = 32'hFFFF_FFFF; bv[31:0] = 32'hFFFF_FFFF; cv[3:0] = 4'd8;
    cycle(4'b0001, cv, av, bv, 1'b1, g);
    check("t1_grant", 64'(g), 64'b0001);
    #1 check("t1_dsp_cmd", 64'(dut.w_dsp_cmd), 64'd8);
    cycle(4'b0000, cv, av, bv, 1'b1, g);
    #1;
    check("t1_valid", 64'(resp_valid), 64'd1);
    check("t1_id", 64'(resp_id), 64'd0);
    check("t1_result", resp_result, 64'hFFFF_FFFE_0000_0001);
    check("t1_err", 64'(resp_err), 64'd0);
    cycle(4'b0000, cv, av, bv, 1'b1, g);

    // Illegal command from req1.
    cv = '0; av = '0; bv = '0;
    cv[7:4] = 4'd5; av[63:32] = 32'd7; bv[63:32] = 32'd9;
    cycle(4'b0010, cv, av, bv, 1'b1, g);
    check("t4_grant", 64'(g), 64'b0010);
    #1 check("t4_dsp_cmd", 64'(dut.w_dsp_cmd), 64'd0);
    cycle(4'b0000, cv, av, bv, 1'b1, g);
    #1;
    check("t4_valid", 64'(resp_valid), 64'd1);
    check("t4_err", 64'(resp_err), 64'd1);
    check("t4_result", resp_result, 64'd0);
    check("t4_id", 64'(resp_id), 64'd1);
    cycle(4'b0000, cv, av, bv, 1'b1, g);

    // Lone req2 with pointer at 3, then lone req3.
    cv = '0; av = {4{32'd11}}; bv = {4{32'd13}};
    cycle(4'b0100, cv, av, bv, 1'b1, g);
    check("t6_grant_a", 64'(g), 64'b0100);
    cycle(4'b0100, cv, av, bv, 1'b1, g);
    check("t6_grant_b", 64'(g), 64'b0100);
    #1 check("t6_ptr", 64'(dut.u_arb.r_ptr), 64'd3);
    cycle(4'b1000, cv, av, bv, 1'b1, g);
    check("t6_grant_c", 64'(g), 64'b1000);
    repeat (3) cycle(4'b0000, cv, av, bv, 1'b1, g);

    // Backpressure after the first response.
    for (int i = 0; i < NREQ; i++) begin
      cv[4*i +: 4] = 4'd8; av[32*i +: 32] = 32'd100 + 32'(i); bv[32*i +: 32] = 32'd3;
    end
    cycle(4'b1111, cv, av, bv, 1'b1, g);
    cycle(4'b1111, cv, av, bv, 1'b1, g);
    for (int s = 0; s < 5; s++) begin
      cycle(4'b1111, cv, av, bv, 1'b0, g);
      if (s >= 1) check("t3_stall_ready", 64'(g), 64'd0);
    end
    repeat (6) cycle(4'b0000, cv, av, bv, 1'b1, g);

    // Reset with both stages full.
    cycle(4'b1111, cv, av, bv, 1'b0, g);
    cycle(4'b1111, cv, av, bv, 1'b0, g);
    cycle(4'b1111, cv, av, bv, 1'b0, g);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_valid", 64'(resp_valid), 64'd0);
    check("t5_result", resp_result, 64'd0);
    check("t5_err", 64'(resp_err), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_ready", 64'(req_ready), 64'd0);
    q.delete();
    m_ptr = 0;
    @(posedge clk);
    req_valid = '0;
    @(negedge clk) reset = 1'b1;

    // Every requester always valid: grants rotate, one response per cycle.
    cv = '0; av = {4{32'd3}}; bv = {4{32'd5}};
    for (int k = 0; k < 10; k++) begin
      cycle(4'b1111, cv, av, bv, 1'b1, g);
      check("t2_grant", 64'(g), 64'(1 << (k % 4)));
      if (k >= 2) check("t2_result", resp_result, 64'd15);
    end
    repeat (3) cycle(4'b0000, cv, av, bv, 1'b1, g);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        cv[4*i +: 4]   = 4'($urandom_range(0, 15));
        av[32*i +: 32] = rnd32();
        bv[32*i +: 32] = rnd32();
      end
      cycle(NREQ'($urandom), cv, av, bv, ($urandom_range(0, 3) != 0), g);
    end
    repeat (4) cycle(4'b0000, cv, av, bv, 1'b1, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
